// File: rtl/defuzz_divider_pkg.sv
// rtl/defuzz_divider_pkg.sv - shared constants and FSM state codes for the defuzzifier divider
package defuzz_divider_pkg;

  localparam logic [15:0] Q15_MAX   = 16'h7FFF;
  localparam int          G_MAX_DEF = 100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/defuzz_divider_seq_udiv.sv
// rtl/defuzz_divider_seq_udiv.sv - generic W-bit sequential restoring divider, one quotient bit per cycle
module seq_udiv #(
  parameter int W = 22
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] quo
);

  localparam int CW = $clog2(W);

  logic [W:0]    rem_q;
  logic [W-1:0]  num_q;
  logic [W-1:0]  den_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

  logic [W:0] rem_sh;
  logic [W:0] rem_nx;
  logic       ge;

  // Numerator register shifts out MSB-first and fills with quotient bits from the LSB.
  assign rem_sh = {rem_q[W-1:0], num_q[W-1]};
  assign ge     = rem_sh >= {1'b0, den_q};
  assign rem_nx = ge ? (rem_sh - {1'b0, den_q}) : rem_sh;
  assign quo    = {num_q[W-2:0], ge};

  // done marks the cycle whose edge retires the last bit, so quo is final right now.
  assign done = busy_q && (cnt_q == CW'(W - 1));
  assign busy = busy_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      num_q  <= '0;
      den_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      num_q  <= num;
      den_q  <= den;
      cnt_q  <= '0;
      busy_q <= 1'b1;
    end else if (busy_q) begin
      rem_q <= rem_nx;
      num_q <= quo;
      cnt_q <= cnt_q + CW'(1);
      if (done) begin
        busy_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/defuzz_divider.sv
// rtl/defuzz_divider.sv - crisp output G = round(100*S_wg/S_w) with handshakes, clamp and zero-weight bypass
module defuzz_divider
  import defuzz_divider_pkg::*;
#(
  parameter int NUM_W     = 22,
  parameter int G_MAX     = G_MAX_DEF,
  parameter int G_DEFAULT = 50,
  parameter int ROUND     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] S_w,
  input  logic [15:0] S_wg,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  G,
  output logic        zero_w,
  output logic        sat,
  output logic        busy
);

  state_t state, state_nx;

  logic [14:0]      w15, wg15;
  logic             accept, w_zero, div_start, div_done;
  logic             unused_div_busy;
  logic [NUM_W-1:0] num, den, quo;

  assign w15  = 15'(S_w & Q15_MAX);
  assign wg15 = 15'(S_wg & Q15_MAX);

  assign in_ready  = (state == ST_IDLE);
  assign out_valid = (state == ST_DONE);
  assign busy      = (state == ST_DIV);

  assign accept    = in_valid && in_ready;
  assign w_zero    = (w15 == 15'd0);
  assign div_start = accept && !w_zero;

  // Adding half the divisor up front turns the truncating divide into round-half-up.
  assign num = NUM_W'(wg15) * NUM_W'(100) + ((ROUND != 0) ? NUM_W'(w15 >> 1) : '0);
  assign den = NUM_W'(w15);

  seq_udiv #(
    .W(NUM_W)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .num   (num),
    .den   (den),
    .busy  (unused_div_busy),
    .done  (div_done),
    .quo   (quo)
  );

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (accept)    state_nx = w_zero ? ST_DONE : ST_DIV;
      ST_DIV:  if (div_done)  state_nx = ST_DONE;
      ST_DONE: if (out_ready) state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      G      <= '0;
      zero_w <= 1'b0;
      sat    <= 1'b0;
    end else begin
      state <= state_nx;
      if (accept && w_zero) begin
        G      <= 8'(G_DEFAULT);
        zero_w <= 1'b1;
        sat    <= 1'b0;
      end else if (div_done) begin
        zero_w <= 1'b0;
        if (quo > NUM_W'(G_MAX)) begin
          G   <= 8'(G_MAX);
          sat <= 1'b1;
        end else begin
          G   <= quo[7:0];
          sat <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_defuzz_divider.sv
// tb/tb_defuzz_divider.sv - scoreboard bench for defuzz_divider (ROUND=1 and ROUND=0 instances in lockstep)
module tb_defuzz_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] S_w = '0;
  logic [15:0] S_wg = '0;

  logic       in_ready, out_valid, zero_w, sat, busy;
  logic [7:0] G;
  logic       in_ready_t, out_valid_t, zero_w_t, sat_t, busy_t;
  logic [7:0] G_t;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int g1;
    int s1;
    int g0;
    int s0;
    int z;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  defuzz_divider #(.ROUND(1)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .S_w(S_w), .S_wg(S_wg), .out_valid(out_valid), .out_ready(out_ready),
    .G(G), .zero_w(zero_w), .sat(sat), .busy(busy)
  );

  defuzz_divider #(.ROUND(0)) u_dut_t (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
    .S_w(S_w), .S_wg(S_wg), .out_valid(out_valid_t), .out_ready(out_ready),
    .G(G_t), .zero_w(zero_w_t), .sat(sat_t), .busy(busy_t)
  );

  function automatic exp_t model(int w_in, int wg_in);
    exp_t e;
    int w, wg, q1, q0;
    w  = w_in & 32'h7FFF;
    wg = wg_in & 32'h7FFF;
    if (w == 0) begin
      e.g1 = 50; e.s1 = 0; e.g0 = 50; e.s0 = 0; e.z = 1;
    end else begin
      q1 = (wg * 100 + w / 2) / w;
      q0 = (wg * 100) / w;
      e.z  = 0;
      e.s1 = (q1 > 100) ? 1 : 0;
      e.g1 = (q1 > 100) ? 100 : q1;
      e.s0 = (q0 > 100) ? 1 : 0;
      e.g0 = (q0 > 100) ? 100 : q0;
    end
    return e;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per completed output handshake.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("unexpected_result", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("G_round", int'(G), e.g1);
        check("sat_round", int'(sat), e.s1);
        check("zero_w", int'(zero_w), e.z);
        check("G_trunc", int'(G_t), e.g0);
        check("sat_trunc", int'(sat_t), e.s0);
        check("zero_w_trunc", int'(zero_w_t), e.z);
        check("out_valid_trunc", int'(out_valid_t), 1);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #2;
      n++;
    end
    check("in_ready_wait", int'(in_ready), 1);
  endtask

  task automatic run_op(input logic [15:0] w, input logic [15:0] wg, input int hold);
    int lat;
    logic [7:0] g_h;
    logic z_h, s_h;
    wait_ready();
    out_ready = (hold == 0);
    in_valid  = 1'b1;
    S_w       = w;
    S_wg      = wg;
    sb.push_back(model(int'(w), int'(wg)));
    @(posedge clk); #2;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #2;
      lat++;
    end
    // Zero weight: result is present in the cycle right after accept; otherwise 22 edges later.
    check("latency", lat, (w[14:0] == 15'd0) ? 0 : 22);
    if (hold > 0) begin
      g_h = G; z_h = zero_w; s_h = sat;
      for (int i = 0; i < hold; i++) begin
        in_valid = 1'b1;
        S_w      = 16'($urandom);
        S_wg     = 16'($urandom);
        @(posedge clk); #2;
        check("hold_G", int'(G), int'(g_h));
        check("hold_flags", int'({zero_w, sat}), int'({z_h, s_h}));
        check("hold_in_ready", int'(in_ready), 0);
        check("hold_out_valid", int'(out_valid), 1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #2;
      check("release_out_valid", int'(out_valid), 0);
      check("release_in_ready", int'(in_ready), 1);
    end else begin
      @(posedge clk); #2;
    end
  endtask

  task automatic abort_op();
    wait_ready();
    out_ready = 1'b1;
    in_valid  = 1'b1;
    S_w       = 16'h3000;
    S_wg      = 16'h1000;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk); #2;
    end
    check("abort_busy_before", int'(busy), 1);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    check("abort_out_valid", int'(out_valid), 0);
    check("abort_G", int'(G), 0);
    check("abort_flags", int'({zero_w, sat, busy}), 0);
    check("abort_in_ready", int'(in_ready), 1);
    repeat (25) begin
      @(posedge clk); #2;
      if (out_valid) check("abort_stale_result", 1, 0);
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_G", int'(G), 0);
    check("rst_flags", int'({zero_w, sat, busy}), 0);
    check("rst_in_ready", int'(in_ready), 1);

    run_op(16'h4000, 16'h2000, 0);
    run_op(16'h0000, 16'h1234, 0);
    run_op(16'h7FFF, 16'h7FFF, 0);
    run_op(16'h0100, 16'h0200, 0);
    run_op(16'h0003, 16'h0001, 0);
    run_op(16'h0003, 16'h0002, 0);
    run_op(16'h1000, 16'h0000, 0);
    run_op(16'h8000, 16'h0050, 0);
    run_op(16'h4000, 16'h2000, 5);
    run_op(16'h0000, 16'h7FFF, 5);
    abort_op();
    run_op(16'h2000, 16'h0800, 0);

    for (int k = 0; k < 30; k++) begin
      logic [15:0] w, wg;
      int sel;
      sel = int'($urandom_range(0, 3));
      case (sel)
        0: w = 16'h0000 | 16'($urandom_range(0, 1) << 15);
        1: w = 16'($urandom_range(1, 15));
        default: w = 16'($urandom);
      endcase
      wg = 16'($urandom);
      run_op(w, wg, int'($urandom_range(0, 3)));
    end

    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_empty", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
